vector_mul_seq: RTL and testbench



---
 rtl/vector_mul_seq_if.sv | 29 ++
 rtl/vector_mul_seq.sv | 135 +++++++++++++
 tb/tb_vector_mul_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_mul_seq_if.sv
// Memory and multiplier port bundle for vector_mul_seq.
// The sequencer is the master; the memories and multiplier sit on the slave side.
interface vector_mul_seq_if #(
    parameter int unsigned LANES = 5,
    parameter int unsigned AW    = 7
);
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [LANES*32-1:0] rd_data_a;
    logic [LANES*32-1:0] rd_data_b;
    logic [LANES*32-1:0] mul_a;
    logic [LANES*32-1:0] mul_b;
    logic [LANES*32-1:0] mul_res;
    logic                wr_valid;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [LANES*32-1:0] wr_data;
    logic [LANES-1:0]    wr_mask;

    modport master (
        output rd_en, rd_addr, mul_a, mul_b, wr_valid, wr_addr, wr_data, wr_mask,
        input  rd_data_a, rd_data_b, mul_res, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, mul_a, mul_b, wr_valid, wr_addr, wr_data, wr_mask,
        output rd_data_a, rd_data_b, mul_res, wr_ready
    );
endinterface

// File: rtl/vector_mul_seq.sv
// Chunked sequencer: reads LANES-wide operand chunks, feeds the shared multiplier and
// writes masked result chunks, one chunk per READ/CAPTURE/WRITE round.
module vector_mul_seq #(
    parameter int unsigned LANES = 5,
    parameter int unsigned TOTAL = 400,
    parameter int unsigned AW    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      len,
    output logic             busy,
    output logic             done,
    output logic             err,
    vector_mul_seq_if.master bus
);
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam int unsigned DW = LANES * 32;

    typedef enum logic [1:0] {StIdle, StRead, StCapture, StWrite} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] c_q, c_d;
    logic [AW-1:0] last_idx_q, last_idx_d;
    logic [CW-1:0] last_cnt_q, last_cnt_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [16:0]      len_ext;
    logic             len_ok;
    logic [CW-1:0]    valid_cnt;
    logic [LANES-1:0] lane_valid;

    assign len_ext = {1'b0, len};
    assign len_ok  = (len != 16'd0) && (len_ext <= 17'(TOTAL));

    // Only the final chunk can be partial.
    assign valid_cnt = (c_q == last_idx_q) ? last_cnt_q : CW'(LANES);

    always_comb begin
        lane_valid = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_valid[i] = CW'(i) < valid_cnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        last_idx_d = last_idx_q;
        last_cnt_d = last_cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        // last_idx = nchunk - 1 = floor((len - 1) / LANES)
                        last_idx_d = AW'((len_ext - 17'd1) / 17'(LANES));
                        last_cnt_d = CW'(len_ext - 17'(LANES) * ((len_ext - 17'd1) / 17'(LANES)));
                        c_d        = '0;
                        state_d    = StRead;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRead: state_d = StCapture;
            StCapture: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    op_a_d[32*i +: 32] = lane_valid[i] ? bus.rd_data_a[32*i +: 32] : 32'd0;
                    op_b_d[32*i +: 32] = lane_valid[i] ? bus.rd_data_b[32*i +: 32] : 32'd0;
                end
                state_d = StWrite;
            end
            StWrite: begin
                if (bus.wr_ready) begin
                    if (c_q == last_idx_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        c_d     = c_q + AW'(1);
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.rd_en    = state_q == StRead;
        bus.rd_addr  = (state_q == StRead) ? c_q : '0;
        bus.wr_valid = state_q == StWrite;
        bus.wr_addr  = (state_q == StWrite) ? c_q : '0;
        bus.wr_mask  = (state_q == StWrite) ? lane_valid : '0;
        bus.wr_data  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (state_q == StWrite && lane_valid[i]) begin
                bus.wr_data[32*i +: 32] = bus.mul_res[32*i +: 32];
            end
        end
        bus.mul_a = op_a_q;
        bus.mul_b = op_b_q;
        busy      = state_q != StIdle;
        done      = done_q;
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            c_q        <= '0;
            last_idx_q <= '0;
            last_cnt_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            last_idx_q <= last_idx_d;
            last_cnt_q <= last_cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_vector_mul_seq.sv
// Directed bench for vector_mul_seq with behavioural operand memories and multiplier.
module tb_vector_mul_seq;
    localparam int unsigned LANES = 5;
    localparam int unsigned TOTAL = 400;
    localparam int unsigned AW    = 7;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len   = 16'd0;
    logic        busy, done, err;

    vector_mul_seq_if #(.LANES(LANES), .AW(AW)) bus ();

    vector_mul_seq #(.LANES(LANES), .TOTAL(TOTAL), .AW(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .len  (len),
        .busy (busy),
        .done (done),
        .err  (err),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int mem_a [TOTAL];
    int mem_b [TOTAL];

    function automatic int ref_mul(input int a, input int b);
        return (a / 50000000) * (b / 43);
    endfunction

    always @(posedge clk) begin
        if (bus.rd_en) begin
            for (int i = 0; i < int'(LANES); i++) begin
                bus.rd_data_a[32*i +: 32] <= mem_a[int'(bus.rd_addr) * int'(LANES) + i];
                bus.rd_data_b[32*i +: 32] <= mem_b[int'(bus.rd_addr) * int'(LANES) + i];
            end
        end
    end

    always_comb begin
        bus.mul_res = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            bus.mul_res[32*i +: 32] = ref_mul(bus.mul_a[32*i +: 32], bus.mul_b[32*i +: 32]);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0, busy_cnt = 0, err_cnt = 0, err_cyc = 0, done_cnt = 0, done_cyc = 0;
    int both_cnt = 0;
    logic [AW-1:0]       wq_addr [$];
    logic [LANES*32-1:0] wq_data [$];
    logic [LANES-1:0]    wq_mask [$];

    always @(negedge clk) begin
        if (bus.rd_en) rd_cnt <= rd_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (done && err) both_cnt <= both_cnt + 1;
        if (bus.wr_valid && bus.wr_ready) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            wq_mask.push_back(bus.wr_mask);
        end
    end

    // t0 is the edge that accepted start; cycle n after it is the period where cyc == t0+n-1.
    int t0 = 0, rd0 = 0, busy0 = 0, err0 = 0, done0 = 0, both0 = 0, w0 = 0;

    task automatic snap();
        t0    = cyc;
        rd0   = rd_cnt;
        busy0 = busy_cnt;
        err0  = err_cnt;
        done0 = done_cnt;
        both0 = both_cnt;
        w0    = wq_addr.size();
    endtask

    task automatic kick(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 16'(l);
        @(posedge clk); #1;
        start = 1'b0;
        snap();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (done_cnt != done0) break;
        end
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({busy, done, err, bus.rd_en, bus.wr_valid, bus.rd_addr, bus.wr_addr, bus.wr_mask} !== '0)
        begin
            n_err++;
            $display("FAIL reset_ctrl: got %h want 0",
                     {busy, done, err, bus.rd_en, bus.wr_valid, bus.rd_addr, bus.wr_addr, bus.wr_mask});
        end
        n_vec++;
        if ({bus.mul_a, bus.mul_b, bus.wr_data} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {bus.mul_a, bus.mul_b, bus.wr_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        n_vec++;
        if (busy_cnt + rd_cnt + err_cnt + done_cnt !== 0) begin
            n_err++; $display("FAIL reset_quiet: got %0d events want 0",
                              busy_cnt + rd_cnt + err_cnt + done_cnt);
        end
    endtask

    task automatic test_single_chunk();
        for (int j = 0; j < 10; j++) begin
            mem_a[j] = 100000000;
            mem_b[j] = 86;
        end
        kick(5);
        wait_done(20);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 4) begin
            n_err++; $display("FAIL single_done: got cnt %0d cycle %0d want 1 cycle 4",
                              done_cnt - done0, done_cyc - t0 + 1);
        end
        n_vec++;
        if (rd_cnt - rd0 !== 1 || busy_cnt - busy0 !== 3) begin
            n_err++; $display("FAIL single_rd_busy: got rd %0d busy %0d want 1 3",
                              rd_cnt - rd0, busy_cnt - busy0);
        end
        n_vec++;
        if (wq_addr.size() - w0 !== 1 || wq_addr[w0] !== 7'd0 || wq_mask[w0] !== 5'b11111 ||
            wq_data[w0] !== {5{32'd4}}) begin
            n_err++; $display("FAIL single_write: got n %0d addr %0d mask %b data %h want 1 0 11111 4s",
                              wq_addr.size() - w0, wq_addr[w0], wq_mask[w0], wq_data[w0]);
        end
    endtask

    task automatic test_partial();
        logic [LANES*32-1:0] exp0, exp1;
        mem_a[0] = 50000000;   mem_b[0] = 86;
        mem_a[1] = -150000000; mem_b[1] = 100;
        mem_a[2] = 99999999;   mem_b[2] = 43;
        mem_a[3] = 250000000;  mem_b[3] = -129;
        mem_a[4] = 0;          mem_b[4] = 1000;
        mem_a[5] = -100000000; mem_b[5] = -86;
        mem_a[6] = 2000000000; mem_b[6] = 430;
        for (int j = 7; j < 10; j++) begin
            mem_a[j] = 100000000;
            mem_b[j] = 86;
        end
        exp0 = {32'd0, 32'hFFFF_FFF1, 32'd1, 32'hFFFF_FFFA, 32'd2};
        exp1 = {32'd0, 32'd0, 32'd0, 32'd400, 32'd4};
        kick(7);
        wait_done(30);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 7) begin
            n_err++; $display("FAIL partial_done: got cnt %0d cycle %0d want 1 cycle 7",
                              done_cnt - done0, done_cyc - t0 + 1);
        end
        n_vec++;
        if (wq_addr.size() - w0 !== 2) begin
            n_err++; $display("FAIL partial_nwr: got %0d want 2", wq_addr.size() - w0);
        end
        n_vec++;
        if (wq_addr[w0] !== 7'd0 || wq_mask[w0] !== 5'b11111 || wq_data[w0] !== exp0) begin
            n_err++; $display("FAIL partial_wr0: got addr %0d mask %b data %h want 0 11111 %h",
                              wq_addr[w0], wq_mask[w0], wq_data[w0], exp0);
        end
        n_vec++;
        if (wq_addr[w0+1] !== 7'd1 || wq_mask[w0+1] !== 5'b00011 || wq_data[w0+1] !== exp1) begin
            n_err++; $display("FAIL partial_wr1: got addr %0d mask %b data %h want 1 00011 %h",
                              wq_addr[w0+1], wq_mask[w0+1], wq_data[w0+1], exp1);
        end
    endtask

    task automatic test_full_length();
        logic [LANES*32-1:0] e;
        for (int j = 0; j < int'(TOTAL); j++) begin
            mem_a[j] = int'($urandom);
            mem_b[j] = int'($urandom);
        end
        kick(400);
        wait_done(400);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 241) begin
            n_err++; $display("FAIL full_done: got cnt %0d cycle %0d want 1 cycle 241",
                              done_cnt - done0, done_cyc - t0 + 1);
        end
        n_vec++;
        if (rd_cnt - rd0 !== 80 || wq_addr.size() - w0 !== 80 || busy_cnt - busy0 !== 240) begin
            n_err++; $display("FAIL full_counts: got rd %0d wr %0d busy %0d want 80 80 240",
                              rd_cnt - rd0, wq_addr.size() - w0, busy_cnt - busy0);
        end
        for (int k = 0; k < 80; k++) begin
            for (int i = 0; i < int'(LANES); i++) begin
                e[32*i +: 32] = ref_mul(mem_a[5*k+i], mem_b[5*k+i]);
            end
            n_vec++;
            if (wq_addr[w0+k] !== 7'(k) || wq_mask[w0+k] !== 5'b11111 || wq_data[w0+k] !== e) begin
                n_err++; $display("FAIL full_chunk%0d: got addr %0d mask %b data %h want %0d 11111 %h",
                                  k, wq_addr[w0+k], wq_mask[w0+k], wq_data[w0+k], k, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*32-1:0] exp0, exp1;
        for (int j = 0; j < 10; j++) begin
            mem_a[j] = 50000000 * (j + 1);
            mem_b[j] = 43 * (j + 1);
        end
        exp0 = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        exp1 = {32'd100, 32'd81, 32'd64, 32'd49, 32'd36};
        bus.wr_ready = 1'b0;
        kick(10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wr_valid) break;
        end
        n_vec++;
        if (cyc - t0 + 1 !== 3) begin
            n_err++; $display("FAIL bp_first_write: got cycle %0d want 3", cyc - t0 + 1);
        end
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            n_vec++;
            if ({bus.wr_valid, bus.wr_addr, bus.wr_mask, bus.rd_en} !== {1'b1, 7'd0, 5'b11111, 1'b0} ||
                bus.wr_data !== exp0) begin
                n_err++; $display("FAIL bp_stall%0d: got v %b addr %0d mask %b rd %b data %h want 1 0 11111 0 %h",
                                  k, bus.wr_valid, bus.wr_addr, bus.wr_mask, bus.rd_en, bus.wr_data, exp0);
            end
        end
        @(posedge clk); #1;
        bus.wr_ready = 1'b1;
        wait_done(30);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 10 || busy_cnt - busy0 !== 9) begin
            n_err++; $display("FAIL bp_done: got cnt %0d cycle %0d busy %0d want 1 10 9",
                              done_cnt - done0, done_cyc - t0 + 1, busy_cnt - busy0);
        end
        n_vec++;
        if (wq_addr.size() - w0 !== 2 || wq_data[w0] !== exp0 || wq_addr[w0+1] !== 7'd1 ||
            wq_mask[w0+1] !== 5'b11111 || wq_data[w0+1] !== exp1) begin
            n_err++; $display("FAIL bp_writes: got n %0d d0 %h a1 %0d m1 %b d1 %h want 2 %h 1 11111 %h",
                              wq_addr.size() - w0, wq_data[w0], wq_addr[w0+1], wq_mask[w0+1],
                              wq_data[w0+1], exp0, exp1);
        end
    endtask

    task automatic test_errors();
        int bad [2];
        bad = '{0, 401};
        for (int b = 0; b < 2; b++) begin
            kick(bad[b]);
            repeat (4) @(negedge clk);
            #2;
            n_vec++;
            if (err_cnt - err0 !== 1 || err_cyc - t0 + 1 !== 1) begin
                n_err++; $display("FAIL err_pulse_len%0d: got cnt %0d cycle %0d want 1 1",
                                  bad[b], err_cnt - err0, err_cyc - t0 + 1);
            end
            n_vec++;
            if (rd_cnt - rd0 !== 0 || busy_cnt - busy0 !== 0 || done_cnt - done0 !== 0 ||
                both_cnt - both0 !== 0) begin
                n_err++; $display("FAIL err_quiet_len%0d: got rd %0d busy %0d done %0d both %0d want 0",
                                  bad[b], rd_cnt - rd0, busy_cnt - busy0, done_cnt - done0,
                                  both_cnt - both0);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [LANES*32-1:0] exp1;
        exp1 = {32'd100, 32'd81, 32'd64, 32'd49, 32'd36};
        kick(10);
        start = 1'b1;
        len   = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(30);
        repeat (5) @(negedge clk);
        #2;
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 7 || err_cnt - err0 !== 0 ||
            rd_cnt - rd0 !== 2) begin
            n_err++; $display("FAIL busy_start_ctrl: got done %0d cycle %0d err %0d rd %0d want 1 7 0 2",
                              done_cnt - done0, done_cyc - t0 + 1, err_cnt - err0, rd_cnt - rd0);
        end
        n_vec++;
        if (wq_addr.size() - w0 !== 2 || wq_mask[w0+1] !== 5'b11111 || wq_data[w0+1] !== exp1) begin
            n_err++; $display("FAIL busy_start_wr: got n %0d mask %b data %h want 2 11111 %h",
                              wq_addr.size() - w0, wq_mask[w0+1], wq_data[w0+1], exp1);
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*32-1:0] exp0;
        exp0 = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        kick(5);
        wait_done(20);
        // Still inside the done cycle here.
        start = 1'b1;
        len   = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        snap();
        wait_done(20);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 4 || wq_data[w0] !== exp0) begin
            n_err++; $display("FAIL b2b: got done %0d cycle %0d data %h want 1 4 %h",
                              done_cnt - done0, done_cyc - t0 + 1, wq_data[w0], exp0);
        end
    endtask

    task automatic test_reset_mid();
        logic [LANES*32-1:0] exp0;
        int                  done_pre;
        exp0 = {32'd25, 32'd16, 32'd9, 32'd4, 32'd1};
        kick(20);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_valid && bus.wr_addr == 7'd2) break;
        end
        n_vec++;
        if (cyc - t0 + 1 !== 9) begin
            n_err++; $display("FAIL rstmid_locate: got cycle %0d want 9", cyc - t0 + 1);
        end
        done_pre = done_cnt;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, err, bus.rd_en, bus.wr_valid, bus.rd_addr, bus.wr_addr, bus.wr_mask} !== '0 ||
            {bus.mul_a, bus.mul_b, bus.wr_data} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: got busy %b v %b addr %0d mask %b mul_a %h want all 0",
                              busy, bus.wr_valid, bus.wr_addr, bus.wr_mask, bus.mul_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        n_vec++;
        if (done_cnt !== done_pre || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_nodone: got done %0d busy %b want 0 0",
                              done_cnt - done_pre, busy);
        end
        kick(5);
        wait_done(20);
        n_vec++;
        if (done_cnt - done0 !== 1 || done_cyc - t0 + 1 !== 4 || wq_addr.size() - w0 !== 1 ||
            wq_addr[w0] !== 7'd0 || wq_data[w0] !== exp0) begin
            n_err++; $display("FAIL rstmid_restart: got done %0d cycle %0d n %0d data %h want 1 4 1 %h",
                              done_cnt - done0, done_cyc - t0 + 1, wq_addr.size() - w0, wq_data[w0],
                              exp0);
        end
    endtask

    initial begin
        bus.wr_ready = 1'b1;
        test_reset();
        test_single_chunk();
        test_partial();
        test_full_length();
        test_backpressure();
        test_errors();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
